data_mapper_param: RTL and testbench
====================================

// Module: data_mapper_param
// PURPOSE
//  Parametrised serial-in constellation mapper: BPSK/QPSK/16QAM/64QAM, Gray-coded, normalised.
//  Single clock domain (cb_clk); no 80M->20M pulse-stretch crossing.
//  Valid/ready both sides; output FIFO absorbs downstream stalls.
//  Sits between the interleaver bit stream and IFFT subcarrier loader; emits a per-symbol index for the loader.
// PARAMETERS
//  WIDTH  8   I/Q word width, two's complement
//  FRAC   6   fractional bits of I/Q; WIDTH >= FRAC+2 required
//  DEPTH  4   output FIFO depth (power of 2, >=2)
//  NSYM   48  symbols per OFDM symbol; sym_idx wraps at NSYM
//  IDX_W  6   width of sym_idx, 2^IDX_W >= NSYM
// PORTS
//  cb_clk      in   1      clock
//  rst_n       in   1      reset, asynchronous, active-low
//  tx_clr      in   1      synchronous clear, higher priority than all other inputs
//  map_type    in   2      00 BPSK, 01 QPSK, 10 16QAM, 11 64QAM
//  bit_din     in   1      serial coded bit, first bit of a symbol = b0
//  bit_vld     in   1      bit_din valid
//  bit_rdy     out  1      mapper accepts bit when bit_vld&&bit_rdy
//  sym_re      out  WIDTH  I (real) of FIFO head
//  sym_im      out  WIDTH  Q (imag) of FIFO head
//  sym_idx     out  IDX_W  index of head symbol, 0..NSYM-1
//  sym_last    out  1      head symbol has sym_idx==NSYM-1
//  sym_vld     out  1      FIFO non-empty
//  sym_rdy     in   1      pop when sym_vld&&sym_rdy
// BEHAVIOUR
//  Reset/tx_clr: bit counter 0, map stage empty, FIFO empty, index counter 0; outputs all 0, bit_rdy=1 (after reset release).
//  Bits per symbol N: BPSK 1, QPSK 2, 16QAM 4, 64QAM 6.
//  map_type sampled on accepted bit with counter==0 and held until symbol's N-th bit; changes mid-symbol ignored.
//  Accepted bit k stored at b[k]; on N-th accepted bit counter->0 and symbol loads map stage next cycle.
//  Map stage: 1 register; writes FIFO with {re,im,idx} following cycle; idx counter +1, NSYM-1 -> 0.
//  Latency: N-th bit accepted at cycle t -> sym_vld at t+2 when FIFO empty and downstream ready.
//  Amplitude A(L) = round(L*K*2^FRAC), K: BPSK 1, QPSK 1/sqrt2, 16QAM 1/sqrt10, 64QAM 1/sqrt42; -L in two's complement.
//  FRAC=6 table: BPSK 64; QPSK 45; 16QAM L1=20,L3=61; 64QAM L1=10,L3=30,L5=49,L7=69.
//  BPSK: re=b0?+1:-1, im=0.  QPSK: re=b0?+1:-1, im=b1?+1:-1.
//  16QAM re(b0b1)/im(b2b3): 00 -3, 01 -1, 11 +1, 10 +3.
//  64QAM re(b0b1b2)/im(b3b4b5): 000 -7,001 -5,011 -3,010 -1,110 +1,111 +3,101 +5,100 +7.
//  Flow control: bit_rdy = (fifo_count + map_stage_full) < DEPTH; never overflows, no bits dropped.
//  FIFO first-word-fall-through; simultaneous push and pop when full-1 or empty legal, count unchanged.
//  Output fields stable while sym_vld&&!sym_rdy.
//  tx_clr same cycle as bit_vld: bit dropped; mid-symbol: partial bits discarded, next bit is b0.
//  Async reset mid-symbol: identical to tx_clr result.
// TESTING
//  16QAM, bits 1,0,1,1 -> sym_re=8'h3D(+61), sym_im=8'h14(+20), sym_idx=0, sym_vld at t+2.
//  64QAM, bits 1,0,0,0,0,0 -> sym_re=8'h45(+69), sym_im=8'hBB(-69); BPSK bit 0 -> re=8'hC0, im=0.
//  sym_rdy=0, 16QAM stream: 4 symbols fill FIFO, bit_rdy=0 then; release -> 4 symbols in order, none lost.
//  QPSK 48 symbols back-to-back -> sym_idx 0..47, sym_last only at 47, 49th symbol idx=0.
//  16QAM 2 bits, map_type->BPSK, 2 more bits -> one 16QAM symbol; then BPSK symbols per bit.
//  tx_clr after 3 of 6 64QAM bits -> no output; next 6 bits form symbol idx=0, FIFO empty before.

Source files
------------

// File: rtl/data_mapper_param.sv
// Serial-bit constellation mapper (BPSK/QPSK/16QAM/64QAM, Gray-coded, normalised)
// with a one-register map stage feeding a first-word-fall-through output FIFO.
module data_mapper_param #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 6,
    parameter int DEPTH = 4,
    parameter int NSYM  = 48,
    parameter int IDX_W = 6
) (
    input  logic             cb_clk,
    input  logic             rst_n,
    input  logic             tx_clr,
    input  logic [1:0]       map_type,
    input  logic             bit_din,
    input  logic             bit_vld,
    output logic             bit_rdy,
    output logic [WIDTH-1:0] sym_re,
    output logic [WIDTH-1:0] sym_im,
    output logic [IDX_W-1:0] sym_idx,
    output logic             sym_last,
    output logic             sym_vld,
    input  logic             sym_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // round(l * 2^FRAC / sqrt(d)) in integers: counts x with (x + 0.5) <= exact value
    function automatic int amp(input int l, input int d);
        longint lim;
        longint t;
        int     r;
        lim = longint'(l * l) << (2 * FRAC + 2);
        r   = 0;
        for (int x = 0; x < (2 << FRAC); x++) begin
            t = longint'(2 * x + 1);
            if (t * t * longint'(d) <= lim) r = x + 1;
        end
        return r;
    endfunction

    localparam logic [WIDTH-1:0] A_BPSK = WIDTH'(amp(1, 1));
    localparam logic [WIDTH-1:0] A_QPSK = WIDTH'(amp(1, 2));
    localparam logic [WIDTH-1:0] A16_1  = WIDTH'(amp(1, 10));
    localparam logic [WIDTH-1:0] A16_3  = WIDTH'(amp(3, 10));
    localparam logic [WIDTH-1:0] A64_1  = WIDTH'(amp(1, 42));
    localparam logic [WIDTH-1:0] A64_3  = WIDTH'(amp(3, 42));
    localparam logic [WIDTH-1:0] A64_5  = WIDTH'(amp(5, 42));
    localparam logic [WIDTH-1:0] A64_7  = WIDTH'(amp(7, 42));

    function automatic logic [2:0] nbits(input logic [1:0] t);
        case (t)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd6;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] sgn(input logic pos, input logic [WIDTH-1:0] a);
        return pos ? a : -a;
    endfunction

    function automatic logic [WIDTH-1:0] mag64(input logic m1, input logic m0);
        case ({m1, m0})
            2'b00:   return A64_7;
            2'b01:   return A64_5;
            2'b11:   return A64_3;
            default: return A64_1;
        endcase
    endfunction

    logic [2:0]       bcnt_q, bcnt_d;
    logic [5:0]       bits_q, bits_d, bits_cur;
    logic [1:0]       type_q, type_d, cur_type;
    logic             map_full_q, map_full_d;
    logic [5:0]       mbits_q, mbits_d;
    logic [1:0]       mtype_q, mtype_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CW-1:0]    fcnt_q, fcnt_d;
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] map_re, map_im;
    logic             accept, last_bit, push, pop;

    logic [WIDTH-1:0] re_mem_q  [DEPTH];
    logic [WIDTH-1:0] im_mem_q  [DEPTH];
    logic [IDX_W-1:0] idx_mem_q [DEPTH];

    // Occupancy includes the map stage, so a push always finds a free slot.
    assign bit_rdy  = (int'(fcnt_q) + int'(map_full_q)) < DEPTH;
    assign accept   = bit_vld && bit_rdy;
    assign cur_type = (bcnt_q == 3'd0) ? map_type : type_q;
    assign last_bit = (bcnt_q == nbits(cur_type) - 3'd1);
    assign push     = map_full_q;
    assign pop      = sym_vld && sym_rdy;

    always_comb begin
        bits_cur          = bits_q;
        bits_cur[bcnt_q]  = bit_din;
    end

    always_comb begin
        map_re = '0;
        map_im = '0;
        case (mtype_q)
            2'b00: map_re = sgn(mbits_q[0], A_BPSK);
            2'b01: begin
                map_re = sgn(mbits_q[0], A_QPSK);
                map_im = sgn(mbits_q[1], A_QPSK);
            end
            2'b10: begin
                map_re = sgn(mbits_q[0], mbits_q[1] ? A16_1 : A16_3);
                map_im = sgn(mbits_q[2], mbits_q[3] ? A16_1 : A16_3);
            end
            default: begin
                map_re = sgn(mbits_q[0], mag64(mbits_q[1], mbits_q[2]));
                map_im = sgn(mbits_q[3], mag64(mbits_q[4], mbits_q[5]));
            end
        endcase
    end

    always_comb begin
        bcnt_d     = bcnt_q;
        bits_d     = bits_q;
        type_d     = type_q;
        map_full_d = 1'b0;
        mbits_d    = mbits_q;
        mtype_d    = mtype_q;
        idx_d      = idx_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fcnt_d     = fcnt_q + CW'(push) - CW'(pop);
        if (accept) begin
            if (last_bit) begin
                bcnt_d     = 3'd0;
                mbits_d    = bits_cur;
                mtype_d    = cur_type;
                map_full_d = 1'b1;
            end else begin
                bcnt_d = bcnt_q + 3'd1;
                bits_d = bits_cur;
                type_d = cur_type;
            end
        end
        if (push) begin
            wptr_d = wptr_q + AW'(1);
            idx_d  = (idx_q == IDX_W'(NSYM - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        if (pop) rptr_d = rptr_q + AW'(1);
        if (tx_clr) begin
            bcnt_d     = '0;
            bits_d     = '0;
            type_d     = '0;
            map_full_d = 1'b0;
            idx_d      = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            fcnt_d     = '0;
        end
    end

    always_ff @(posedge cb_clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q     <= '0;
            bits_q     <= '0;
            type_q     <= '0;
            map_full_q <= 1'b0;
            mbits_q    <= '0;
            mtype_q    <= '0;
            idx_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fcnt_q     <= '0;
        end else begin
            bcnt_q     <= bcnt_d;
            bits_q     <= bits_d;
            type_q     <= type_d;
            map_full_q <= map_full_d;
            mbits_q    <= mbits_d;
            mtype_q    <= mtype_d;
            idx_q      <= idx_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fcnt_q     <= fcnt_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge cb_clk) begin
        if (push && !tx_clr) begin
            re_mem_q[wptr_q]  <= map_re;
            im_mem_q[wptr_q]  <= map_im;
            idx_mem_q[wptr_q] <= idx_q;
        end
    end

    assign sym_vld  = (fcnt_q != '0);
    assign sym_re   = sym_vld ? re_mem_q[rptr_q]  : '0;
    assign sym_im   = sym_vld ? im_mem_q[rptr_q]  : '0;
    assign sym_idx  = sym_vld ? idx_mem_q[rptr_q] : '0;
    assign sym_last = sym_vld && (idx_mem_q[rptr_q] == IDX_W'(NSYM - 1));
endmodule

// File: tb/tb_data_mapper_param.sv
// Directed and random stimulus for data_mapper_param, checked against a
// symbol-level reference model (real-valued amplitudes, Gray tables, queue).
module tb_data_mapper_param;
    localparam int WIDTH = 8;
    localparam int FRAC  = 6;
    localparam int DEPTH = 4;
    localparam int NSYM  = 48;
    localparam int IDX_W = 6;

    logic             cb_clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tx_clr = 1'b0;
    logic [1:0]       map_type = 2'b00;
    logic             bit_din = 1'b0;
    logic             bit_vld = 1'b0;
    logic             bit_rdy;
    logic [WIDTH-1:0] sym_re;
    logic [WIDTH-1:0] sym_im;
    logic [IDX_W-1:0] sym_idx;
    logic             sym_last;
    logic             sym_vld;
    logic             sym_rdy = 1'b0;

    data_mapper_param #(.WIDTH(WIDTH), .FRAC(FRAC), .DEPTH(DEPTH), .NSYM(NSYM), .IDX_W(IDX_W)) dut (
        .cb_clk(cb_clk), .rst_n(rst_n), .tx_clr(tx_clr), .map_type(map_type),
        .bit_din(bit_din), .bit_vld(bit_vld), .bit_rdy(bit_rdy),
        .sym_re(sym_re), .sym_im(sym_im), .sym_idx(sym_idx), .sym_last(sym_last),
        .sym_vld(sym_vld), .sym_rdy(sym_rdy)
    );

    always #5 cb_clk = ~cb_clk;

    typedef struct {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        int               idx;
    } sym_t;

    int   n_assert = 0;
    int   n_fail = 0;
    sym_t exp_q[$];
    int   part_bits[$];
    logic [1:0] part_type;
    int   m_idx = 0;
    int   pops = 0;
    int   nlast = 0;
    int   g2[4] = '{-3, -1, 3, 1};
    int   g3[8] = '{-7, -5, -1, -3, 7, 5, 1, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int nb(input logic [1:0] t);
        case (t)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 6;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] lvl(input int l, input real k);
        real a;
        a = l * k * (2.0 ** FRAC);
        return WIDTH'($rtoi(a < 0.0 ? a - 0.5 : a + 0.5));
    endfunction

    task automatic model_clear();
        part_bits.delete();
        exp_q.delete();
        m_idx = 0;
    endtask

    task automatic model_bit(input logic b);
        sym_t s;
        int   b_[6];
        int   rl, il;
        real  k;
        if (part_bits.size() == 0) part_type = map_type;
        part_bits.push_back(int'(b));
        if (part_bits.size() == nb(part_type)) begin
            for (int i = 0; i < 6; i++) b_[i] = (i < part_bits.size()) ? part_bits[i] : 0;
            case (part_type)
                2'd0: begin k = 1.0; rl = b_[0] ? 1 : -1; il = 0; end
                2'd1: begin k = 1.0 / $sqrt(2.0); rl = b_[0] ? 1 : -1; il = b_[1] ? 1 : -1; end
                2'd2: begin k = 1.0 / $sqrt(10.0); rl = g2[b_[0]*2 + b_[1]]; il = g2[b_[2]*2 + b_[3]]; end
                default: begin
                    k  = 1.0 / $sqrt(42.0);
                    rl = g3[b_[0]*4 + b_[1]*2 + b_[2]];
                    il = g3[b_[3]*4 + b_[4]*2 + b_[5]];
                end
            endcase
            s.re  = lvl(rl, k);
            s.im  = lvl(il, k);
            s.idx = m_idx;
            exp_q.push_back(s);
            m_idx = (m_idx + 1) % NSYM;
            part_bits.delete();
        end
    endtask

    // Called at a falling edge with inputs settled: account for the handshakes
    // the coming rising edge will perform, then advance one cycle.
    task automatic tick();
        sym_t e;
        if (tx_clr) begin
            model_clear();
        end else begin
            if (sym_vld && sym_rdy) begin
                chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pop_re", 32'(sym_re), 32'(e.re));
                    chk("pop_im", 32'(sym_im), 32'(e.im));
                    chk("pop_idx", 32'(sym_idx), 32'(e.idx));
                    chk("pop_last", 32'(sym_last), 32'(e.idx == NSYM - 1));
                end
                pops++;
                if (sym_last) nlast++;
            end
            if (bit_vld && bit_rdy) model_bit(bit_din);
        end
        @(posedge cb_clk);
        @(negedge cb_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        bit_vld = 1'b1;
        bit_din = b;
        for (int i = 0; i < 64 && !bit_rdy; i++) tick();
        if (!bit_rdy) chk("bit_rdy_timeout", 32'(bit_rdy), 32'd1);
        tick();
        bit_vld = 1'b0;
    endtask

    task automatic send_sym(input logic [1:0] t, input logic [5:0] bits);
        map_type = t;
        for (int i = 0; i < nb(t); i++) send_bit(bits[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] h_re, h_im;
        int p0;

        // Reset
        repeat (3) @(negedge cb_clk);
        rst_n = 1'b1;
        @(negedge cb_clk);
        chk("rst_vld", 32'(sym_vld), 32'd0);
        chk("rst_re", 32'(sym_re), 32'd0);
        chk("rst_im", 32'(sym_im), 32'd0);
        chk("rst_idx", 32'(sym_idx), 32'd0);
        chk("rst_last", 32'(sym_last), 32'd0);
        chk("rst_bit_rdy", 32'(bit_rdy), 32'd1);

        // 16QAM 1,0,1,1: latency and values
        sym_rdy  = 1'b1;
        map_type = 2'd2;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        chk("lat_t1_vld", 32'(sym_vld), 32'd0);
        tick();
        chk("lat_t2_vld", 32'(sym_vld), 32'd1);
        chk("qam16_re", 32'(sym_re), 32'h3D);
        chk("qam16_im", 32'(sym_im), 32'h14);
        chk("qam16_idx", 32'(sym_idx), 32'd0);
        idle(2);

        // 64QAM 1,0,0,0,0,0 then BPSK 0
        sym_rdy = 1'b0;
        send_sym(2'd3, 6'b000001);
        tick();
        chk("qam64_re", 32'(sym_re), 32'h45);
        chk("qam64_im", 32'(sym_im), 32'hBB);
        sym_rdy = 1'b1;
        tick();
        sym_rdy = 1'b0;
        send_sym(2'd0, 6'b000000);
        tick();
        chk("bpsk_re", 32'(sym_re), 32'hC0);
        chk("bpsk_im", 32'(sym_im), 32'h00);
        sym_rdy = 1'b1;
        idle(2);

        // Backpressure: four 16QAM symbols fill the FIFO
        sym_rdy = 1'b0;
        for (int s = 0; s < DEPTH; s++) send_sym(2'd2, 6'($urandom));
        idle(2);
        chk("full_bit_rdy", 32'(bit_rdy), 32'd0);
        chk("full_vld", 32'(sym_vld), 32'd1);
        h_re = sym_re;
        h_im = sym_im;
        idle(3);
        chk("stall_re_stable", 32'(sym_re), 32'(h_re));
        chk("stall_im_stable", 32'(sym_im), 32'(h_im));
        p0 = pops;
        sym_rdy = 1'b1;
        idle(8);
        chk("drain_count", 32'(pops - p0), 32'(DEPTH));
        chk("drain_empty", 32'(sym_vld), 32'd0);

        // QPSK 49 symbols back-to-back from a cleared index
        tx_clr = 1'b1;
        tick();
        tx_clr = 1'b0;
        nlast = 0;
        p0 = pops;
        map_type = 2'd1;
        for (int i = 0; i < 2 * (NSYM + 1); i++) send_bit(1'($urandom));
        idle(4);
        chk("qpsk_pops", 32'(pops - p0), 32'(NSYM + 1));
        chk("qpsk_nlast", 32'(nlast), 32'd1);

        // map_type change mid-symbol is ignored
        p0 = pops;
        map_type = 2'd2;
        send_bit(1'($urandom)); send_bit(1'($urandom));
        map_type = 2'd0;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        idle(4);
        chk("midtype_pops", 32'(pops - p0), 32'd4);

        // tx_clr after 3 of 6 64QAM bits
        map_type = 2'd3;
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        tx_clr = 1'b1;
        tick();
        tx_clr = 1'b0;
        idle(3);
        chk("clr_no_out", 32'(sym_vld), 32'd0);
        sym_rdy = 1'b0;
        send_sym(2'd3, 6'($urandom));
        tick();
        chk("clr_vld", 32'(sym_vld), 32'd1);
        chk("clr_idx", 32'(sym_idx), 32'd0);
        sym_rdy = 1'b1;
        idle(2);

        // tx_clr together with bit_vld drops the bit
        map_type = 2'd0;
        bit_vld  = 1'b1;
        bit_din  = 1'b1;
        tx_clr   = 1'b1;
        tick();
        tx_clr  = 1'b0;
        bit_vld = 1'b0;
        idle(3);
        chk("clr_drop_bit", 32'(sym_vld), 32'd0);

        // Async reset mid-symbol
        map_type = 2'd3;
        send_bit(1'b1); send_bit(1'b1);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_clear();
        @(negedge cb_clk);
        sym_rdy = 1'b0;
        send_sym(2'd3, 6'($urandom));
        tick();
        chk("arst_vld", 32'(sym_vld), 32'd1);
        chk("arst_idx", 32'(sym_idx), 32'd0);
        sym_rdy = 1'b1;
        idle(2);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            map_type = 2'($urandom_range(0, 3));
            bit_vld  = ($urandom % 4) != 0;
            bit_din  = 1'($urandom);
            sym_rdy  = ($urandom % 3) != 0;
            tx_clr   = ($urandom % 150) == 0;
            tick();
        end
        bit_vld = 1'b0;
        tx_clr  = 1'b0;
        sym_rdy = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        chk("rand_drain", 32'(exp_q.size()), 32'd0);
        chk("rand_empty", 32'(sym_vld), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
